wb_master_bridge: RTL and testbench

- Wishbone initiator that turns single CPU load/store requests into one Wishbone transaction on the master port of the system interconnect.
- Holds STB until the addressed slave ACKs, then returns read data and a one-cycle completion pulse.
- A timeout counter ends transactions to slaves that never ACK, such as unpopulated 256 MB regions (ADDR[31:28]). These complete with an error flag and a fixed read value.
- Sits between the CPU memory stage and the interconnect.

---
 rtl/wb_master_bridge_if.sv | 30 +++
 rtl/wb_master_bridge.sv | 76 +++++++
 tb/tb_wb_master_bridge.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/wb_master_bridge_if.sv
// CPU-side request/response and Wishbone master signals of wb_master_bridge.
// The master modport is the bridge's view; slave is the CPU/interconnect side.
interface wb_master_bridge_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        cpu_err;
  logic        cpu_busy;
  logic        wb_STB;
  logic        wb_WE;
  logic [31:0] wb_ADDR;
  logic [31:0] wb_DAT_O;
  logic [31:0] wb_DAT_I;
  logic        wb_ACK;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, wb_DAT_I, wb_ACK,
    output cpu_rdata, cpu_ready, cpu_err, cpu_busy,
    output wb_STB, wb_WE, wb_ADDR, wb_DAT_O
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, wb_DAT_I, wb_ACK,
    input  cpu_rdata, cpu_ready, cpu_err, cpu_busy,
    input  wb_STB, wb_WE, wb_ADDR, wb_DAT_O
  );
endinterface

// File: rtl/wb_master_bridge.sv
// Single-transaction Wishbone initiator: one CPU load/store becomes one STB
// cycle, ended by ACK or by a timeout that reports an error and ERR_DATA.
module wb_master_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input logic               clk,
  input logic               rst_n,
  wb_master_bridge_if.master bus
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [15:0] tmo_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      tmo_cnt       <= '0;
      bus.wb_STB    <= 1'b0;
      bus.wb_WE     <= 1'b0;
      bus.wb_ADDR   <= '0;
      bus.wb_DAT_O  <= '0;
      bus.cpu_rdata <= '0;
      bus.cpu_ready <= 1'b0;
      bus.cpu_err   <= 1'b0;
      bus.cpu_busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cpu_req) begin
            bus.wb_WE    <= bus.cpu_we;
            bus.wb_ADDR  <= bus.cpu_addr;
            bus.wb_DAT_O <= bus.cpu_wdata;
            bus.wb_STB   <= 1'b1;
            bus.cpu_busy <= 1'b1;
            tmo_cnt      <= '0;
            state        <= BUS;
          end
        end
        BUS: begin
          // ACK is checked first so it wins over a timeout on the same edge.
          if (bus.wb_ACK) begin
            bus.wb_STB    <= 1'b0;
            if (!bus.wb_WE) begin
              bus.cpu_rdata <= bus.wb_DAT_I;
            end
            bus.cpu_err   <= 1'b0;
            bus.cpu_ready <= 1'b1;
            state         <= DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            bus.wb_STB    <= 1'b0;
            bus.cpu_rdata <= ERR_DATA;
            bus.cpu_err   <= 1'b1;
            bus.cpu_ready <= 1'b1;
            state         <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        DONE: begin
          bus.cpu_ready <= 1'b0;
          bus.cpu_busy  <= 1'b0;
          state         <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed bench for wb_master_bridge: two instances (timeouts 8 and 4) sharing
// CPU stimulus, each with its own STB-counting ACK responder.
module tb_wb_master_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sel;
  logic        req, we, ack_en;
  logic [31:0] addr, wdata, dat_i;
  logic [7:0]  ack_dly;
  logic [7:0]  cnt8 = 8'd0;
  logic [7:0]  cnt4 = 8'd0;

  int n_pass  = 0;
  int n_total = 0;

  wb_master_bridge_if if8();
  wb_master_bridge_if if4();

  assign if8.cpu_req   = req & ~sel;
  assign if8.cpu_we    = we;
  assign if8.cpu_addr  = addr;
  assign if8.cpu_wdata = wdata;
  assign if8.wb_DAT_I  = dat_i;
  assign if8.wb_ACK    = ack_en & if8.wb_STB & (cnt8 >= ack_dly);

  assign if4.cpu_req   = req & sel;
  assign if4.cpu_we    = we;
  assign if4.cpu_addr  = addr;
  assign if4.cpu_wdata = wdata;
  assign if4.wb_DAT_I  = dat_i;
  assign if4.wb_ACK    = ack_en & if4.wb_STB & (cnt4 >= ack_dly);

  always @(posedge clk) begin
    cnt8 <= if8.wb_STB ? cnt8 + 8'd1 : 8'd0;
    cnt4 <= if4.wb_STB ? cnt4 + 8'd1 : 8'd0;
  end

  wb_master_bridge #(.TIMEOUT_CYCLES(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.master));
  wb_master_bridge #(.TIMEOUT_CYCLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.master));

  logic        o_stb, o_we, o_ready, o_err, o_busy;
  logic [31:0] o_addr, o_dato, o_rdata;

  always_comb begin
    if (sel) begin
      o_stb = if4.wb_STB;  o_we = if4.wb_WE;  o_addr = if4.wb_ADDR;  o_dato = if4.wb_DAT_O;
      o_ready = if4.cpu_ready; o_err = if4.cpu_err; o_busy = if4.cpu_busy; o_rdata = if4.cpu_rdata;
    end else begin
      o_stb = if8.wb_STB;  o_we = if8.wb_WE;  o_addr = if8.wb_ADDR;  o_dato = if8.wb_DAT_O;
      o_ready = if8.cpu_ready; o_err = if8.cpu_err; o_busy = if8.cpu_busy; o_rdata = if8.cpu_rdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    string       name;
    logic        s;        // 0 = timeout-8 instance, 1 = timeout-4 instance
    logic        w;
    logic [31:0] a, wd, di;
    logic        ack_on;
    logic [7:0]  dly;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int unsigned exp_stb;
  } vec_t;

  vec_t tbl[9];

  task automatic run(input vec_t v);
    int n;
    logic early;
    n = 0;
    early = 1'b0;
    @(negedge clk);
    sel = v.s; we = v.w; addr = v.a; wdata = v.wd; dat_i = v.di;
    ack_en = v.ack_on; ack_dly = v.dly; req = 1'b1;
    @(negedge clk);
    // scramble CPU inputs while busy; the bus side must not follow them
    req = 1'b0; we = ~v.w; addr = ~v.a; wdata = ~v.wd;
    while (o_stb && n < 64) begin
      check({v.name, " addr"}, o_addr, v.a);
      check({v.name, " we"},   {31'd0, o_we}, {31'd0, v.w});
      check({v.name, " dato"}, o_dato, v.wd);
      if (o_ready) early = 1'b1;
      n++;
      @(negedge clk);
    end
    check({v.name, " stb_cycles"}, 32'(n), 32'(v.exp_stb));
    check({v.name, " early_ready"}, {31'd0, early}, 32'd0);
    check({v.name, " ready"}, {31'd0, o_ready}, 32'd1);
    check({v.name, " busy_done"}, {31'd0, o_busy}, 32'd1);
    check({v.name, " rdata"}, o_rdata, v.exp_rdata);
    check({v.name, " err"}, {31'd0, o_err}, {31'd0, v.exp_err});
    @(negedge clk);
    check({v.name, " ready_end"}, {31'd0, o_ready}, 32'd0);
    check({v.name, " busy_end"}, {31'd0, o_busy}, 32'd0);
    check({v.name, " rdata_hold"}, o_rdata, v.exp_rdata);
    check({v.name, " err_hold"}, {31'd0, o_err}, {31'd0, v.exp_err});
    ack_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a_cur;
    tbl[0] = '{"rd_comb_ack", 1'b0, 1'b0, 32'h2000_0010, 32'h0,          32'h1234_5678, 1'b1, 8'd0, 32'h1234_5678, 1'b0, 1};
    tbl[1] = '{"wr_ack3",     1'b0, 1'b1, 32'h3000_0004, 32'hCAFE_0001, 32'h9999_9999, 1'b1, 8'd3, 32'h1234_5678, 1'b0, 4};
    tbl[2] = '{"rd_timeout",  1'b0, 1'b0, 32'hF000_0000, 32'h0,          32'h7777_7777, 1'b0, 8'd0, 32'hDEAD_BEEF, 1'b1, 8};
    tbl[3] = '{"rd_ack1",     1'b0, 1'b0, 32'h1000_0020, 32'h0,          32'hA5A5_0F0F, 1'b1, 8'd1, 32'hA5A5_0F0F, 1'b0, 2};
    tbl[4] = '{"wr_timeout",  1'b0, 1'b1, 32'hF000_0100, 32'h0BAD_0001, 32'h0,          1'b0, 8'd0, 32'hDEAD_BEEF, 1'b1, 8};
    tbl[5] = '{"wr_comb_ack", 1'b0, 1'b1, 32'h0000_0000, 32'h1111_2222, 32'h3333_4444, 1'b1, 8'd0, 32'hDEAD_BEEF, 1'b0, 1};
    tbl[6] = '{"t4_ack_at_limit", 1'b1, 1'b0, 32'h5000_0000, 32'h0,      32'h0BAD_F00D, 1'b1, 8'd3, 32'h0BAD_F00D, 1'b0, 4};
    tbl[7] = '{"t4_wr_timeout",   1'b1, 1'b1, 32'h6000_0000, 32'h1234_0000, 32'h0,      1'b0, 8'd0, 32'hDEAD_BEEF, 1'b1, 4};
    tbl[8] = '{"t4_rd_ack2",      1'b1, 1'b0, 32'h7000_0008, 32'h0,      32'h5555_AAAA, 1'b1, 8'd2, 32'h5555_AAAA, 1'b0, 3};

    sel = 1'b0; req = 1'b0; we = 1'b0; ack_en = 1'b0; ack_dly = 8'd0;
    addr = '0; wdata = '0; dat_i = '0;

    // reset state of both instances
    repeat (2) @(negedge clk);
    check("rst8_stb",   {31'd0, if8.wb_STB},    32'd0);
    check("rst8_busy",  {31'd0, if8.cpu_busy},  32'd0);
    check("rst8_ready", {31'd0, if8.cpu_ready}, 32'd0);
    check("rst8_err",   {31'd0, if8.cpu_err},   32'd0);
    check("rst8_rdata", if8.cpu_rdata, 32'd0);
    check("rst8_addr",  if8.wb_ADDR,   32'd0);
    check("rst8_dato",  if8.wb_DAT_O,  32'd0);
    check("rst8_we",    {31'd0, if8.wb_WE},     32'd0);
    check("rst4_stb",   {31'd0, if4.wb_STB},    32'd0);
    check("rst4_busy",  {31'd0, if4.cpu_busy},  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run(tbl[i]);

    // back-to-back: req held, immediate ACK, address changes every cycle
    @(negedge clk);
    sel = 1'b0; we = 1'b0; ack_en = 1'b1; ack_dly = 8'd0; dat_i = 32'h0101_0101;
    a_cur = 32'h4000_0000; addr = a_cur; req = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      check($sformatf("b2b_stb_%0d", i), {31'd0, o_stb}, {31'd0, (i % 3 == 1)});
      check($sformatf("b2b_ready_%0d", i), {31'd0, o_ready}, {31'd0, (i % 3 == 2)});
      if (i % 3 == 1) check($sformatf("b2b_addr_%0d", i), o_addr, a_cur);
      a_cur = 32'h4000_0000 + 32'(i * 4);
      addr = a_cur;
      if (i == 9) req = 1'b0;
    end
    @(negedge clk);
    check("b2b_idle_busy", {31'd0, o_busy}, 32'd0);
    ack_en = 1'b0;

    // reset during the second STB cycle of a transaction
    @(negedge clk);
    sel = 1'b0; we = 1'b0; addr = 32'hF000_0000; req = 1'b1; ack_en = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    req = 1'b0;
    check("rstmid_stb_before", {31'd0, o_stb}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rstmid_stb",   {31'd0, o_stb},   32'd0);
    check("rstmid_busy",  {31'd0, o_busy},  32'd0);
    check("rstmid_ready", {31'd0, o_ready}, 32'd0);
    check("rstmid_rdata", o_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("rstmid_noready_%0d", i), {31'd0, o_ready}, 32'd0);
    end
    run('{"post_rst_rd", 1'b0, 1'b0, 32'h2000_0040, 32'h0, 32'hFEED_0042, 1'b1, 8'd0, 32'hFEED_0042, 1'b0, 1});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
